// File: rtl/opti_sos_ctrl.sv
// Sample sequencer and double-buffered coefficient manager for one opti_sos biquad.
// Issues one sample at a time and waits for its result, with a watchdog on the section.
module opti_sos_ctrl #(
    parameter int          DW       = 24,
    parameter int          CW       = 24,
    parameter logic [CW-1:0] COEF_ONE = CW'(24'h400000),
    parameter int          TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] sec_data_in,
    output logic          sec_valid_in,
    input  logic [DW-1:0] sec_data_out,
    input  logic          sec_valid_out,
    output logic [CW-1:0] sec_b0,
    output logic [CW-1:0] sec_b1,
    output logic [CW-1:0] sec_b2,
    output logic [CW-1:0] sec_a1,
    output logic [CW-1:0] sec_a2,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          busy,
    output logic          timeout_err,
    input  logic          err_clr
);

    localparam int CNTW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CNTW-1:0] cnt;
    logic [CW-1:0]   shd_q [5];
    logic [CW-1:0]   act_q [5];

    logic accept;
    logic swap;
    logic resp;
    logic tmo;

    assign s_ready      = (state == IDLE) && !m_valid && !cfg_pending;
    assign accept       = s_valid && s_ready;
    assign swap         = (state == IDLE) && cfg_pending;
    assign resp         = (state == WAIT) && sec_valid_out;
    assign tmo          = (state == WAIT) && !sec_valid_out
                          && (cnt == CNTW'(TIMEOUT - 1));
    assign sec_valid_in = (state == ISSUE);
    assign busy         = (state != IDLE);

    assign sec_b0 = act_q[0];
    assign sec_b1 = act_q[1];
    assign sec_b2 = act_q[2];
    assign sec_a1 = act_q[3];
    assign sec_a2 = act_q[4];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (resp || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Watchdog counter saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_data_in <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
        end else begin
            if (accept) sec_data_in <= s_data;
            if (resp) begin
                m_data  <= sec_data_out;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (tmo) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    // Active copies the pre-write shadow; a commit during the swap re-arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                shd_q[i] <= (i == 0) ? COEF_ONE : '0;
                act_q[i] <= (i == 0) ? COEF_ONE : '0;
            end
            cfg_pending <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (cfg_we && cfg_addr == 3'(i)) shd_q[i] <= cfg_wdata;
                if (swap) act_q[i] <= shd_q[i];
            end
            if (swap) begin
                cfg_pending <= cfg_commit;
            end else if (cfg_commit) begin
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opti_sos_ctrl.sv
// Scoreboard bench for opti_sos_ctrl with an echoing section model
// of programmable latency.
module tb_opti_sos_ctrl;

    localparam int DW = 24;
    localparam int CW = 24;
    localparam logic [CW-1:0] ONE = 24'h400000;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] sec_data_in;
    logic          sec_valid_in;
    logic [DW-1:0] sec_data_out;
    logic          sec_valid_out;
    logic [CW-1:0] sec_b0, sec_b1, sec_b2, sec_a1, sec_a2;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          cfg_pending;
    logic          busy;
    logic          timeout_err;
    logic          err_clr;

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] sb[$];

    int   lat;
    logic sec_en;
    int   cd;
    logic [DW-1:0] echo;

    opti_sos_ctrl #(
        .DW(DW), .CW(CW), .COEF_ONE(ONE), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .sec_data_in(sec_data_in), .sec_valid_in(sec_valid_in),
        .sec_data_out(sec_data_out), .sec_valid_out(sec_valid_out),
        .sec_b0(sec_b0), .sec_b1(sec_b1), .sec_b2(sec_b2),
        .sec_a1(sec_a1), .sec_a2(sec_a2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Section model: result valid L+1 edges after valid_in is sampled
    always @(posedge clk) begin
        if (!rst_n) begin
            cd <= 0;
        end else if (sec_valid_in) begin
            cd   <= lat + 1;
            echo <= sec_data_in;
        end else if (cd > 0) begin
            cd <= cd - 1;
        end
    end
    assign sec_valid_out = sec_en && (cd == 1);
    assign sec_data_out  = echo;

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) sb.push_back(s_data);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("sb_data", 32'(m_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) chk("send_timeout", 32'd1, 32'd0);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_mv(output int k, output logic rdy_seen);
        k = 0;
        rdy_seen = 1'b0;
        while (!m_valid && k < 40) begin
            tick();
            k++;
            if (s_ready) rdy_seen = 1'b1;
        end
        if (!m_valid) chk("mvalid_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int   k;
        logic rs;
        logic bad;
        logic [DW-1:0] md;

        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        err_clr = 1'b0; lat = 4; sec_en = 1'b1;
        tick(); tick();
        chk("rst_b0", 32'(sec_b0), 32'(ONE));
        chk("rst_a1", 32'(sec_a1), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pend", 32'(cfg_pending), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Passthrough
        send(24'h000123);
        chk("p_vin", 32'(sec_valid_in), 32'd1);
        chk("p_din", 32'(sec_data_in), 32'h123);
        chk("p_srdy", 32'(s_ready), 32'd0);
        tick();
        chk("p_vin_pulse", 32'(sec_valid_in), 32'd0);
        wait_mv(k, rs);
        chk("p_latency", 32'(k + 1), 32'd6);
        chk("p_srdy_low", 32'(rs), 32'd0);
        chk("p_mdata", 32'(m_data), 32'h123);
        tick();

        // Backpressure
        m_ready = 1'b0;
        send(24'h0abcde);
        wait_mv(k, rs);
        md = m_data;
        s_valid = 1'b1;
        s_data  = 24'h055555;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_data !== md || s_ready !== 1'b0 || !m_valid) bad = 1'b1;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        m_ready = 1'b1;
        tick();
        chk("bp_drain", 32'(m_valid), 32'd0);
        chk("bp_srdy", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("bp_accept", 32'(sec_valid_in), 32'd1);
        chk("bp_din", 32'(sec_data_in), 32'h055555);
        wait_mv(k, rs);
        chk("bp_latency", 32'(k), 32'd6);
        tick();

        // Atomic swap
        send(24'h000777);
        tick();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 24'h200000;
        tick();
        cfg_addr = 3'd3; cfg_wdata = 24'h100000;
        tick();
        cfg_addr = 3'd6; cfg_wdata = 24'hffffff;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("sw_pend", 32'(cfg_pending), 32'd1);
        chk("sw_b0_hold", 32'(sec_b0), 32'(ONE));
        wait_mv(k, rs);
        chk("sw_b0_mv", 32'(sec_b0), 32'(ONE));
        chk("sw_srdy", 32'(s_ready), 32'd0);
        tick();
        chk("sw_b0", 32'(sec_b0), 32'h200000);
        chk("sw_a1", 32'(sec_a1), 32'h100000);
        chk("sw_b1", 32'(sec_b1), 32'd0);
        chk("sw_b2", 32'(sec_b2), 32'd0);
        chk("sw_a2", 32'(sec_a2), 32'd0);
        chk("sw_pend_clr", 32'(cfg_pending), 32'd0);
        chk("sw_srdy_after", 32'(s_ready), 32'd1);

        // Write and commit during the swap cycle
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 24'h000001; cfg_commit = 1'b1;
        tick();
        cfg_wdata = 24'h000002;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("ws_b1_old", 32'(sec_b1), 32'h1);
        chk("ws_rearm", 32'(cfg_pending), 32'd1);
        tick();
        chk("ws_b1_new", 32'(sec_b1), 32'h2);
        chk("ws_pend", 32'(cfg_pending), 32'd0);

        // Timeout
        sec_en = 1'b0;
        send(24'h000999);
        k = 0;
        bad = 1'b0;
        while (!timeout_err && k < 30) begin
            tick();
            k++;
            if (m_valid) bad = 1'b1;
        end
        chk("to_cycles", 32'(k), 32'd9);
        chk("to_no_mv", 32'(bad), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        send(24'h000aaa);
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_set_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", 32'(timeout_err), 32'd0);
        chk("to_sb", 32'(sb.size()), 32'd2);
        sb.delete();

        // Response on the final WAIT cycle
        sec_en = 1'b1;
        lat = 7;
        send(24'h000bbb);
        wait_mv(k, rs);
        chk("col_latency", 32'(k), 32'd9);
        chk("col_err", 32'(timeout_err), 32'd0);
        tick();
        chk("col_err2", 32'(timeout_err), 32'd0);

        // Reset mid-WAIT
        lat = 4;
        send(24'h000456);
        tick(); tick();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 24'h300000;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("rw_pend", 32'(cfg_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_pend0", 32'(cfg_pending), 32'd0);
        chk("rw_b0", 32'(sec_b0), 32'(ONE));
        chk("rw_a1", 32'(sec_a1), 32'd0);
        chk("rw_b1", 32'(sec_b1), 32'd0);
        chk("rw_din", 32'(sec_data_in), 32'd0);
        chk("rw_mv", 32'(m_valid), 32'd0);
        tick(); tick();
        sb.delete();
        rst_n = 1'b1;
        tick();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        chk("rw_shd_b0", 32'(sec_b0), 32'(ONE));
        chk("rw_shd_a1", 32'(sec_a1), 32'd0);
        send(24'h000321);
        wait_mv(k, rs);
        chk("rw_latency", 32'(k), 32'd6);
        tick(); tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
